dmem_responder: RTL and testbench

//  Data-memory responder: the memory-side end of the core's data port (data_addr, datamem_wr, data_out0..3, data_in).

---
 rtl/dmem_responder_pkg.sv | 19 +
 rtl/dmem_array.sv | 30 +++
 rtl/dmem_responder.sv | 165 ++++++++++++++++
 tb/tb_dmem_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder (FSM encodings, default map, request payload).
package dmem_responder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [31:0] DEF_ADDR_BASE = 32'h0000_1000;
    localparam logic [31:0] DEF_MMIO_ADDR = 32'h0000_FF00;

    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/dmem_array.sv
// Four 8-bit byte-lane banks with synchronous per-lane write and registered read.
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [7:0] lane_rd_q [4];

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] bank [DEPTH_WORDS];

        always_ff @(posedge clk) begin
            if (we[i]) begin
                bank[addr] <= wdata[8*i +: 8];
            end
            lane_rd_q[i] <= bank[addr];
        end
    end

    always_comb begin
        rdata = {lane_rd_q[3], lane_rd_q[2], lane_rd_q[1], lane_rd_q[0]};
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_STATES wait cycles, then a one-cycle ack.
// Optional MMIO register enabled by defining DMEM_MMIO_EN.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = DEF_ADDR_BASE,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] MMIO_ADDR   = DEF_MMIO_ADDR
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [3:0]  datamem_wr,
    input  logic [7:0]  data_out0,
    input  logic [7:0]  data_out1,
    input  logic [7:0]  data_out2,
    input  logic [7:0]  data_out3,
    output logic [31:0] data_in,
    output logic        mem_wait,
    output logic        mem_ack,
    output logic        mem_err
`ifdef DMEM_MMIO_EN
    ,
    output logic [31:0] mmio_out
`endif
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    req_t             req_q, req_d, req_in, cur;
    logic             ack_q, ack_d, err_q, err_d, rd_sram_q, rd_sram_d;
    logic             resp_entry, in_range, mmio_hit;
    logic [31:0]      word_off, sram_rdata;
    logic [3:0]       sram_we;

    always_comb begin
        req_in.addr  = {data_addr[31:2], 2'b00};
        req_in.strb  = datamem_wr;
        req_in.wdata = {data_out3, data_out2, data_out1, data_out0};
    end

    // In IDLE the live inputs are the request; afterwards the latched copy is.
    always_comb begin
        cur      = (state_q == ST_IDLE) ? req_in : req_q;
        word_off = cur.addr - ADDR_BASE;
        in_range = (cur.addr >= ADDR_BASE) && ((word_off >> 2) < 32'(DEPTH_WORDS));
    end

`ifdef DMEM_MMIO_EN
    logic [31:0] mmio_q, mmio_d;
    logic        mmio_rd_q, mmio_rd_d;

    always_comb begin
        mmio_hit  = (cur.addr == {MMIO_ADDR[31:2], 2'b00});
        mmio_d    = mmio_q;
        mmio_rd_d = resp_entry && mmio_hit && (cur.strb == 4'b0000);
        for (int i = 0; i < 4; i++) begin
            if (resp_entry && mmio_hit && cur.strb[i]) begin
                mmio_d[8*i +: 8] = cur.wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mmio_q    <= '0;
            mmio_rd_q <= 1'b0;
        end else begin
            mmio_q    <= mmio_d;
            mmio_rd_q <= mmio_rd_d;
        end
    end

    assign mmio_out = mmio_q;
`else
    logic unused_mmio;
    assign mmio_hit    = 1'b0;
    assign unused_mmio = ^MMIO_ADDR;
`endif

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^data_addr[1:0];

    // Next state, wait counter and response flags; the write commits on the edge entering RESP.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        req_d   = req_q;
        case (state_q)
            ST_IDLE: begin
                if (data_req) begin
                    req_d   = req_in;
                    state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                    count_d = (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);
                end
            end
            ST_WAIT: begin
                if (count_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        resp_entry = (state_d == ST_RESP) && (state_q != ST_RESP);
        ack_d      = resp_entry;
        err_d      = resp_entry && !in_range && !mmio_hit;
        rd_sram_d  = resp_entry && in_range && !mmio_hit && (cur.strb == 4'b0000);
        sram_we    = (resp_entry && in_range && !mmio_hit) ? cur.strb : 4'b0000;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            req_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rd_sram_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            req_q     <= req_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rd_sram_q <= rd_sram_d;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (sram_we),
        .addr  (word_off[AW+1:2]),
        .wdata (cur.wdata),
        .rdata (sram_rdata)
    );

    always_comb begin
        data_in = '0;
        if (rd_sram_q) begin
            data_in = sram_rdata;
        end
`ifdef DMEM_MMIO_EN
        if (mmio_rd_q) begin
            data_in = mmio_q;
        end
`endif
    end

    // Stall is combinational so the core freezes in the request cycle itself.
    assign mem_wait = rstn && (((state_q == ST_IDLE) && data_req) || (state_q == ST_WAIT));
    assign mem_ack  = ack_q;
    assign mem_err  = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed steps plus random traffic against a transaction-level memory model.
module tb_dmem_responder;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned W     = 1;
    localparam logic [31:0] MMIO  = 32'h0000_FF00;

    logic        clk = 1'b0;
    logic        rstn;
    logic        data_req;
    logic [31:0] data_addr;
    logic [3:0]  datamem_wr;
    logic [7:0]  data_out0, data_out1, data_out2, data_out3;
    logic [31:0] data_in;
    logic        mem_wait, mem_ack, mem_err;
`ifdef DMEM_MMIO_EN
    logic [31:0] mmio_out;
    logic [31:0] mmio_m = '0;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [31:0] mem_m   [DEPTH];
    logic [3:0]  known_m [DEPTH];

    dmem_responder #(
        .ADDR_BASE   (BASE),
        .DEPTH_WORDS (DEPTH),
        .WAIT_STATES (W),
        .MMIO_ADDR   (MMIO)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .data_req   (data_req),
        .data_addr  (data_addr),
        .datamem_wr (datamem_wr),
        .data_out0  (data_out0),
        .data_out1  (data_out1),
        .data_out2  (data_out2),
        .data_out3  (data_out3),
        .data_in    (data_in),
        .mem_wait   (mem_wait),
        .mem_ack    (mem_ack),
        .mem_err    (mem_err)
`ifdef DMEM_MMIO_EN
        ,
        .mmio_out   (mmio_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd);
        data_addr  = a;
        datamem_wr = s;
        {data_out3, data_out2, data_out1, data_out0} = wd;
    endtask

    // One full transaction: model the expected response, run it, check timing and result.
    task automatic txn(input string tag, input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd);
        logic [31:0] aw, exp_d, mask;
        logic        exp_e, inr;
        int unsigned idx;
        int          lat, waits;
        aw    = a & 32'hFFFF_FFFC;
        inr   = (aw >= BASE) && (((aw - BASE) / 4) < DEPTH);
        idx   = inr ? (aw - BASE) / 4 : 0;
        exp_e = !inr;
        exp_d = '0;
        mask  = '1;
`ifdef DMEM_MMIO_EN
        if (aw == (MMIO & 32'hFFFF_FFFC)) begin
            exp_e = 1'b0;
            if (s == 4'b0000) exp_d = mmio_m;
            for (int i = 0; i < 4; i++) if (s[i]) mmio_m[8*i +: 8] = wd[8*i +: 8];
        end else
`endif
        if (inr) begin
            if (s == 4'b0000) begin
                exp_d = mem_m[idx];
                for (int i = 0; i < 4; i++) mask[8*i +: 8] = known_m[idx][i] ? 8'hFF : 8'h00;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (s[i]) begin
                        mem_m[idx][8*i +: 8] = wd[8*i +: 8];
                        known_m[idx][i] = 1'b1;
                    end
                end
            end
        end

        @(negedge clk);
        data_req = 1'b1;
        drive(a, s, wd);
        #1;
        waits = mem_wait ? 1 : 0;
        @(negedge clk);
        data_req = 1'b0;
        drive($urandom, 4'($urandom), $urandom);
        #1;
        lat = 1;
        while (mem_ack !== 1'b1 && lat < 40) begin
            if (mem_wait) waits++;
            @(negedge clk);
            #1;
            lat++;
        end
        chk({tag, ".ack_latency"}, 32'(lat), 32'(W + 1));
        chk({tag, ".wait_cycles"}, 32'(waits), 32'(W + 1));
        chk({tag, ".wait_in_resp"}, 32'(mem_wait), 32'd0);
        chk({tag, ".err"}, 32'(mem_err), 32'(exp_e));
        if (mask != '0) chk({tag, ".data"}, data_in & mask, exp_d & mask);
        @(negedge clk);
        #1;
        chk({tag, ".ack_one_cycle"}, 32'(mem_ack), 32'd0);
    endtask

    initial begin
        int acks, last, cyc, extra;
        logic [31:0] a;
        logic [3:0]  s;
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i]   = '0;
            known_m[i] = '0;
        end
        rstn = 1'b0;
        data_req = 1'b0;
        drive('0, '0, '0);

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst.data_in", data_in, 32'd0);
        chk("rst.ack", 32'(mem_ack), 32'd0);
        chk("rst.err", 32'(mem_err), 32'd0);
        chk("rst.wait", 32'(mem_wait), 32'd0);
`ifdef DMEM_MMIO_EN
        chk("rst.mmio", mmio_out, 32'd0);
`endif
        @(negedge clk);
        rstn = 1'b1;

        // Fresh read: timing only, contents unknown
        txn("t1_read", BASE, 4'b0000, '0);

        // Byte-lane merge
        txn("t2_wr_all", BASE, 4'b1111, 32'hA5A5_A5A5);
        txn("t2_wr_l1", BASE, 4'b0010, 32'h0000_3C00);
        txn("t2_rd", BASE, 4'b0000, '0);

        // Range boundaries and suppressed out-of-range write
        txn("t3_below", BASE - 4, 4'b0000, '0);
        txn("t3_above", BASE + 4 * DEPTH, 4'b0000, '0);
        txn("t3_last_wr", BASE + 4 * (DEPTH - 1), 4'b1111, 32'h0BAD_CAFE);
        txn("t3_last_rd", BASE + 4 * (DEPTH - 1), 4'b0000, '0);
        txn("t3_oor_wr", BASE + 4 * DEPTH, 4'b1111, 32'hFFFF_FFFF);
        txn("t3_alias_rd", BASE, 4'b0000, '0);
        txn("t3_lsb_rd", BASE + 3, 4'b0000, '0);

        // Held request: four acks with fixed spacing
        @(negedge clk);
        data_req = 1'b1;
        drive(BASE, 4'b0000, '0);
        cyc = 0; acks = 0; last = -1; extra = 0;
        while (acks < 4 && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
            if (mem_ack) begin
                acks++;
                if (last < 0) chk("t4.first_ack", 32'(cyc), 32'(W + 1));
                else          chk("t4.ack_gap", 32'(cyc - last), 32'(W + 2));
                chk("t4.data", data_in, mem_m[0]);
                last = cyc;
                if (acks == 4) data_req = 1'b0;
            end
        end
        chk("t4.acks", 32'(acks), 32'd4);
        repeat (3 * (W + 2)) begin
            @(negedge clk);
            #1;
            if (mem_ack) extra++;
        end
        chk("t4.extra_acks", 32'(extra), 32'd0);

        // Reset in WAIT drops the pending write to word 5
        txn("t5_old", BASE + 20, 4'b1111, 32'h1234_5678);
        @(negedge clk);
        data_req = 1'b1;
        drive(BASE + 20, 4'b1111, 32'hDEAD_BEEF);
        @(negedge clk);
        #1;
        chk("t5.wait_before_rst", 32'(mem_wait), 32'd1);
        rstn = 1'b0;
        #1;
        chk("t5.ack", 32'(mem_ack), 32'd0);
        chk("t5.wait", 32'(mem_wait), 32'd0);
        chk("t5.data", data_in, 32'd0);
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (mem_ack) extra++;
        end
        chk("t5.no_ack", 32'(extra), 32'd0);
        data_req = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        txn("t5_rd", BASE + 20, 4'b0000, '0);

        // MMIO address: register access when enabled, plain out-of-range otherwise
`ifdef DMEM_MMIO_EN
        txn("t6_wr", MMIO, 4'b0001, 32'h0000_00FF);
        chk("t6.mmio_out", mmio_out, mmio_m);
`endif
        txn("t6_rd", MMIO, 4'b0000, '0);

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                7:       a = BASE - 32'($urandom_range(1, 64));
                8:       a = BASE + 4 * DEPTH + 32'($urandom_range(0, 64));
                9:       a = $urandom;
                6:       a = BASE + 4 * (DEPTH - 1) + 32'($urandom_range(0, 3));
                default: a = BASE + 4 * 32'($urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            endcase
            s = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            txn($sformatf("rnd%0d", n), a, s, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
